// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction stream, memory strobe and status bundle for instr_sequencer
interface instr_sequencer_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16
) ();
    logic [INSTR_W-1:0] in_instr;
    logic               in_valid;
    logic               in_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ready;
    logic               done;
    logic               busy;
    logic               err;
    logic               err_clr;

    modport master (
        output in_instr, in_valid, rd_ready, err_clr,
        input  in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, done, busy, err
    );

    modport slave (
        input  in_instr, in_valid, rd_ready, err_clr,
        output in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, done, busy, err
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - FIFO-buffered STORE/LOAD/GO micro-instruction sequencer
// Define INSTR_SEQ_WRAP_EN to let a GO with end < start wrap through the top of the address space.
module instr_sequencer #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_sequencer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_GO    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        BURST = 2'b10,
        DONE  = 2'b11
    } state_t;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  start_q, start_d;
    logic [ADDR_W-1:0]  end_q, end_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0]  ir_addr_q, ir_addr_d;
    logic [DATA_W-1:0]  ir_data_q, ir_data_d;
    logic               err_q, err_d;

    logic               full, empty, push, pop, in_ready;
    logic [INSTR_W-1:0] head;
    logic [1:0]         head_op;
    logic               range_bad, err_set;
    logic               wr_en, rd_en, done;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [DATA_W-1:0]  wr_data;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Held low while reset is asserted so every output reads 0 in reset.
    assign in_ready = rst_n && !full;
    assign push     = bus.in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_op  = head[INSTR_W-1 -: 2];

`ifdef INSTR_SEQ_WRAP_EN
    assign range_bad = 1'b0;
`else
    assign range_bad = (end_q < start_q);
`endif

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        cur_d     = cur_q;
        ir_addr_d = ir_addr_q;
        ir_data_d = ir_data_q;
        pop       = 1'b0;
        err_set   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                // Decode straight off the FIFO head so a LOAD is usable by the very next pop.
                if (!empty) begin
                    pop       = 1'b1;
                    ir_addr_d = head[INSTR_W-3 -: ADDR_W];
                    ir_data_d = head[DATA_W-1:0];
                    case (head_op)
                        OP_STORE: state_d = WRITE;
                        OP_LOAD: begin
                            start_d = head[INSTR_W-3 -: ADDR_W];
                            end_d   = head[ADDR_W-1:0];
                        end
                        OP_GO: begin
                            cur_d = start_q;
                            if (range_bad) begin
                                err_set = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = BURST;
                            end
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = ir_addr_q;
                wr_data = ir_data_q;
                state_d = IDLE;
            end
            BURST: begin
                rd_en   = 1'b1;
                rd_addr = cur_q;
                if (bus.rd_ready) begin
                    if (cur_q == end_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d = cur_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        // A set in the same cycle as a clear must win.
        err_d    = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= IDLE;
            start_q   <= '0;
            end_q     <= '0;
            cur_q     <= '0;
            ir_addr_q <= '0;
            ir_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            cur_q     <= cur_d;
            ir_addr_q <= ir_addr_d;
            ir_data_q <= ir_data_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_instr;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.done     = done;
    assign bus.busy     = (state_q != IDLE) || !empty;
    assign bus.err      = err_q;
endmodule
